// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream sink and instruction-memory write port of the loader.
// latency: none, bundle of wires only.
// backpressure: byte stream is valid/ready, write port is fire-and-forget (no stall).
//
// Signals:
//   byte_valid / byte_data / byte_ready : byte stream, transfer when valid && ready
//   mem_we / mem_waddr / mem_wdata      : single-cycle word write into the IMEM
//
// Modports:
//   master : the loader (sinks bytes, drives the write port)
//   slave  : the environment (sources bytes, observes/implements the write port)
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: reloads the instruction memory from a byte stream while the core is held in reset.
// latency: 2 + 5N cycles from start to done for N words with a gap-free stream.
// backpressure: byte_ready drops only during the one-cycle WRITE slot; stream gaps simply stall.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : one-cycle load request, honoured only when idle or in error
//   bus         : imem_loader_if.master (byte stream in, IMEM write port out)
//   cpu_reset   : holds the core in reset while loading or after a failed load
//   busy        : load in progress
//   done        : one-cycle pulse when a load completes with a good checksum
//   error       : sticky failure flag, cleared by the next start
//
// Stream format: N (1..DEPTH), then 4*N data bytes little-endian per word,
// then one byte equal to the XOR of all data bytes (header excluded).
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  // Word count needs one bit more than the address to hold DEPTH itself.
  localparam int         CNT_W     = ADDR_W + 1;
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Datapath state
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       word_q, word_d;

  // Registered outputs
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic ready;
  logic xfer;
  logic start_ok;
  logic hdr_bad;
  logic last_word;
  logic chk_match;

  // byte_ready is the only output decoded straight from state.
  assign ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign xfer  = bus.byte_valid && ready;

  // start is ignored while busy, so it has no effect outside IDLE/ERR.
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_ERR));

  // Header is compared in 9 bits so DEPTH up to 256 fits without truncation.
  assign hdr_bad = (bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > DEPTH_LIM);

  // count_q >= 1 whenever WRITE is reached, so the subtraction cannot underflow.
  assign last_word = ({1'b0, index_q} == (count_q - CNT_W'(1)));

  assign chk_match = (bus.byte_data == csum_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start_ok) state_d = S_HDR;
      end
      S_HDR: begin
        if (xfer) state_d = hdr_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (xfer && (lane_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = last_word ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (xfer) state_d = chk_match ? S_IDLE : S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output next-values
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    index_d = index_q;
    lane_d  = lane_q;
    csum_d  = csum_q;
    word_d  = word_q;

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start_ok) begin
          csum_d  = 8'd0;
          index_d = '0;
          lane_d  = 2'd0;
        end
      end
      S_HDR: begin
        if (xfer && !hdr_bad) count_d = CNT_W'(bus.byte_data);
      end
      S_DATA: begin
        if (xfer) begin
          // Lane 0 lands in bits [7:0]: little-endian assembly.
          word_d[{lane_q, 3'b000} +: 8] = bus.byte_data;
          lane_d = lane_q + 2'd1;
          csum_d = csum_q ^ bus.byte_data;
        end
      end
      S_WRITE: begin
        // The header range check guarantees index stops at DEPTH-1, never wraps.
        if (!last_word) index_d = index_q + ADDR_W'(1);
      end
      default: begin
      end
    endcase

    // Outputs are registered from the next state, so they line up with
    // the state they describe rather than lagging it by a cycle.
    busy_d      = (state_d == S_HDR) || (state_d == S_DATA) ||
                  (state_d == S_WRITE) || (state_d == S_CHK);
    cpu_reset_d = busy_d || (state_d == S_ERR);
    error_d     = (state_d == S_ERR);
    mem_we_d    = (state_d == S_WRITE);
    done_d      = (state_q == S_CHK) && (state_d == S_IDLE);

    // Entering WRITE, word_d already holds lane 3 and index_d the target slot.
    mem_waddr_d = mem_we_d ? index_d : mem_waddr_q;
    mem_wdata_d = mem_we_d ? word_d  : mem_wdata_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      index_q     <= '0;
      lane_q      <= 2'd0;
      csum_q      <= 8'd0;
      word_q      <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= 32'd0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      index_q     <= index_d;
      lane_q      <= lane_d;
      csum_q      <= csum_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.byte_ready = ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_waddr  = mem_waddr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Sequencer that reprograms the writable instruction memory from a byte-serial stream (UART/debug side) while holding the processor in reset. It parses a one-byte word-count header, assembles little-endian 32-bit words, and issues sequential single-cycle writes to the memory write port. It validates a trailing XOR checksum, then releases the core.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words
ADDR_W, 6, word-address width, equal to clog2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a load; honoured only in IDLE or ERR
byte_valid  in  1  byte_data is valid this cycle
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts a byte this cycle; a transfer is byte_valid && byte_ready
mem_we  out  1  instruction-memory write enable, one cycle per word
mem_waddr  out  ADDR_W  word address (byte address = mem_waddr<<2)
mem_wdata  out  32  word to write
cpu_reset  out  1  holds the core in reset while loading or after an error
busy  out  1  high in HDR, DATA, WRITE and CHK
done  out  1  one-cycle pulse on a successful load
error  out  1  sticky load failure

Behaviour:
- Reset: state=IDLE. All outputs 0: mem_we, mem_waddr, mem_wdata, cpu_reset, busy, done, error. Internal count, index, byte-lane and checksum registers are 0. Reset applies immediately mid-load; a partial image stays in memory and the core runs it.
- All outputs are registered except byte_ready, which is decoded from state.
- IDLE: cpu_reset=0, byte_ready=0. On start, go to HDR, clear checksum, index and lane, and clear error.
- ERR: cpu_reset=1, error=1, byte_ready=0. Only start (go to HDR, clear error) or reset leaves ERR.
- HDR: byte_ready=1. The accepted byte is N.
  - N=0 or N>DEPTH: go to ERR.
  - Otherwise latch N and go to DATA.
  - cpu_reset rises in the cycle after start is accepted and stays 1 through CHK.
- DATA: byte_ready=1.
  - Each accepted byte fills lane 0..3 of the word; lane 0 goes to bits[7:0] (little-endian).
  - Each accepted byte is XORed into the checksum. The header is not included.
  - After lane 3 is accepted, go to WRITE. Gaps where byte_valid=0 simply stall.
- WRITE: byte_ready=0, exactly one cycle. mem_we=1, mem_waddr=index, mem_wdata=assembled word.
  - If index==N-1, go to CHK; otherwise increment index and return to DATA.
  - Index never wraps: the N<=DEPTH check guarantees the last write goes to DEPTH-1.
- CHK: byte_ready=1. The accepted byte is compared with the checksum.
  - Match: go to IDLE, pulse done for one cycle, and drop cpu_reset in the same cycle.
  - Mismatch: go to ERR. cpu_reset stays 1.
- start while busy is ignored and has no side effects.
- mem_we is asserted only in WRITE. mem_waddr and mem_wdata hold their last values otherwise.
- A byte is never accepted in the WRITE cycle. The source must hold byte_valid and byte_data until it sees byte_ready.
- Minimum load time: 2 + 5N cycles after start (header, 4 bytes plus 1 write per word, checksum) with an always-valid stream.

Test Plan:
- Start, stream 02, 13 01 50 00, 93 01 C0 00, checksum 10 -> two writes: waddr 0 / 0x00500113 and waddr 1 / 0x00C00193. Then done pulses once, cpu_reset falls, error=0.
- Same stream with checksum 11 -> both writes occur, state ERR, error=1, cpu_reset stays 1. A new start plus a good stream recovers and sets error=0.
- Header 00, then header 41 (65) -> ERR immediately, no mem_we. byte_ready=0 after the header.
- Header 40 (64) with words 0..63 = index value -> 64 writes, last at waddr 63, no wrap. Checksum = XOR of all bytes -> done.
- byte_valid toggled randomly, plus start pulsed mid-load -> same writes as the gap-free case, start ignored, byte_ready low in every WRITE cycle.
- Reset asserted after the 5th data byte -> all outputs 0 asynchronously and state IDLE. A subsequent start loads normally.
